// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one master port of the data-memory arbiter.
// The master drives request and beat fields; the arbiter returns grant and read data.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data RAM between the CPU (p0) and an auxiliary master (p1).
// Define DMEM_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          mem_en,
    output logic          mem_wen_n,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] LIMIT = 8'(BURST_MAX - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       last, last_nx;
    logic       rvalid0, rvalid1;
    logic       beat0, beat1, at_limit, tie1, yield0, yield1;

    assign beat0    = (state == OWN0) && p0.req;
    assign beat1    = (state == OWN1) && p1.req;
    assign at_limit = cnt == LIMIT;

`ifdef DMEM_ARB_RR_EN
    assign tie1   = ~last;
    assign yield0 = 1'b1;
`else
    assign tie1   = 1'b0;
    assign yield0 = 1'b0;
`endif
    assign yield1 = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            last    <= last_nx;
            rvalid0 <= beat0 & ~p0.we;
            rvalid1 <= beat1 & ~p1.we;
        end
    end

    // Handover at the burst limit goes straight to the peer, so no bubble is inserted.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        case (state)
            IDLE: state_nx = (p0.req && p1.req) ? (tie1 ? OWN1 : OWN0) :
                             p0.req ? OWN0 : p1.req ? OWN1 : IDLE;
            OWN0: begin
                last_nx = 1'b0;
                if (!p0.req) begin
                    state_nx = p1.req ? OWN1 : IDLE;
                    cnt_nx   = '0;
                end else if (at_limit) begin
                    cnt_nx   = '0;
                    state_nx = (p1.req && yield0) ? OWN1 : OWN0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            OWN1: begin
                last_nx = 1'b1;
                if (!p1.req) begin
                    state_nx = p0.req ? OWN0 : IDLE;
                    cnt_nx   = '0;
                end else if (at_limit) begin
                    cnt_nx   = '0;
                    state_nx = (p0.req && yield1) ? OWN0 : OWN1;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign p0.gnt    = state == OWN0;
    assign p1.gnt    = state == OWN1;
    assign p0.rvalid = rvalid0;
    assign p1.rvalid = rvalid1;
    assign p0.rdata  = mem_rdata;
    assign p1.rdata  = mem_rdata;

    assign mem_en    = beat0 | beat1;
    assign mem_wen_n = beat0 ? ~p0.we : beat1 ? ~p1.we : 1'b1;
    assign mem_addr  = (state == OWN1) ? p1.addr : p0.addr;
    assign mem_wdata = (state == OWN1) ? p1.wdata : p0.wdata;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the CPU's single-ported synchronous data memory between the CPU load/store path (port 0) and an auxiliary master such as a program loader or debug/DMA engine (port 1). It owns the memory enable, write-enable and address/data muxing. It grants the port in bounded bursts so neither master starves, and it returns read data with a per-port valid strobe. It sits between the control unit/datapath memory interface and the data RAM.

## Interface
- AW, 8, memory address width
- DW, 16, memory data width
- BURST_MAX, 4, maximum consecutive beats per ownership when the other port is waiting; legal range 1..255
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  access request; held high while the master wants beats
- we0 / we1  in  1  1 = write beat, 0 = read beat
- addr0 / addr1  in  AW  beat address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  registered grant; a beat occurs in every cycle with gntX & reqX
- rvalid0 / rvalid1  out  1  registered; rdataX valid this cycle
- rdata0 / rdata1  out  DW  both driven from mem_rdata; meaningful only with rvalidX
- mem_en  out  1  memory access this cycle
- mem_wen_n  out  1  active-low write enable; 1 = read
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  read data, valid one cycle after a read access

## Operation
- FSM states: IDLE, OWN0, OWN1. gnt0 = (state==OWN0) and gnt1 = (state==OWN1), both taken directly from registers.
- IDLE: no request keeps the FSM in IDLE. A single request moves it to that port's OWN state. If both request, the tie-break rule in Configuration picks the owner.
- OWNx with reqX high is a beat:
  - mem_en=1; mem_addr, mem_wdata and mem_wen_n=~weX come combinationally from port x.
  - Beat counter cnt increments each beat.
- OWNx exit conditions:
  - reqX low → no beat this cycle. Next state is OWNy if reqY is high, otherwise IDLE. cnt clears.
  - Beat with cnt==BURST_MAX-1 and reqY high (subject to Configuration) → next state OWNy, cnt clears. There is no bubble: y's first beat is the next cycle.
  - Beat with cnt==BURST_MAX-1 and reqY low → stay in OWNx, cnt clears.
- Masters keep we/addr/wdata stable while reqX is high and gntX is low. They may change these every cycle while granted.
- rvalidX is registered: it is 1 in the cycle after a read beat by port x. It follows the beat, not the current owner, so it remains correct across a handover.
- mem_en=0 in IDLE and in any OWN cycle with the owner's req low. mem_addr and mem_wdata are don't-care when mem_en=0.
- Round-robin pointer last records the port that most recently owned the memory.

## Timing
- Request to first beat: 1 cycle from IDLE (req sampled at edge, gnt high next cycle). Worst-case wait behind a busy peer is BURST_MAX beats plus 1.
- Read latency: beat in cycle t → rvalidX and valid rdataX in t+1. Write commits at the edge ending the beat cycle.
- Release costs one idle memory cycle: the cycle in which the owner drops req.
- Reset values:
  - state IDLE, cnt 0, last=1 (port 0 wins the first tie)
  - gnt0=gnt1=0, rvalid0=rvalid1=0
  - mem_en=0, mem_wen_n=1
- Reset mid-burst clears everything asynchronously. A pending rvalid is discarded and no further beat occurs.
- A write beat followed by a read of the same address from either port in the next cycle returns the new data. This relies on RAM write-before-read; the arbiter adds no forwarding.

## Configuration
- DMEM_ARB_RR_EN defined (round-robin):
  - IDLE tie goes to the port not equal to last.
  - The burst limit applies symmetrically to both ports.
- DMEM_ARB_RR_EN undefined (fixed priority, port 0 high):
  - IDLE tie goes to port 0.
  - Port 1 is forced off at the burst limit when req0 is high.
  - Port 0 is never forced off; port 1 waits until req0 drops.

## Test plan
- Reset release with req0=1, we0=0, addr0=0x10, RAM[0x10]=0xBEEF → gnt0 high in cycle 1, mem_en in cycle 1, rvalid0=1 with rdata0=0xBEEF in cycle 2.
- Simultaneous req0/req1 from IDLE after reset → port 0 granted. With DMEM_ARB_RR_EN, a second tie after port 0 releases → port 1 granted.
- Both held high continuously, BURST_MAX=4, RR build → strictly alternating 4-beat ownership with no idle cycle between bursts. A fixed build instead keeps gnt0 continuously high.
- Port 1 writes 0x1234 to 0x05, then port 0 reads 0x05 on the first beat after handover → rdata0=0x1234. rvalid1 never asserts for the write.
- Port 0 read beat in the last cycle before handover → rvalid0 asserts in the next cycle while gnt1=1, and rvalid1 stays 0.
- rst_n pulsed low during a port 1 burst → gnt1, rvalid1 and mem_en drop immediately. After release the FSM is in IDLE and the next tie goes to port 0.
